// File: rtl/hyster_pkg.sv
// Shared definitions for the hysteresis RNG sequencer.
//   hseq_state_t : sequencer FSM states
//   DEF_*        : default parameter values for hyster_seq
package hyster_pkg;

   localparam int DEF_WORD_W    = 32;
   localparam int DEF_RST_CYC   = 8;
   localparam int DEF_TIMEOUT   = 4096;
   localparam int DEF_REP_LIMIT = 16;

   typedef enum logic [2:0] {
      IDLE,
      RESET_CORE,
      WAIT_DONE,
      OUTPUT,
      FAIL
   } hseq_state_t;

endpackage

// File: rtl/hyster_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : async active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output
module hyster_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hyster_seq.sv
// Sequencer for the hysteresis ring-oscillator RNG core. Restarts the core
// once per bit, captures each result, packs bits into words (first bit is
// MSB), runs a repetition-count health test and a per-bit timeout, and
// hands finished words to one consumer over valid/ready.
//   clk, rst                 : system clock, async active-high reset
//   en                       : run request (level)
//   clr                      : one-cycle pulse, clears sticky errors / leaves FAIL
//   core_rst_b               : active-low reset to the core
//   core_done, core_bit      : core result, asynchronous to clk
//   rnd_word, rnd_valid      : output word and its valid
//   rnd_ready                : consumer accept
//   busy                     : not in IDLE and not in FAIL
//   health_fail, timeout_err : sticky error flags
//
// state      | meaning
// IDLE       | core held in reset, waiting for en
// RESET_CORE | core held in reset for RST_CYC cycles
// WAIT_DONE  | core released, waiting for done or timeout
// OUTPUT     | word presented, waiting for the handshake
// FAIL       | health or timeout error, waiting for clr
module hyster_seq
   import hyster_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int RST_CYC   = DEF_RST_CYC,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   output logic              core_rst_b,
   input  logic              core_done,
   input  logic              core_bit,
   output logic [WORD_W-1:0] rnd_word,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              health_fail,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(WORD_W + 1);

   hseq_state_t       state, state_nxt;
   logic [7:0]        rst_cnt, rst_cnt_nxt;
   logic [15:0]       tmo_cnt, tmo_cnt_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [WORD_W-1:0] word_nxt;
   logic              last_bit, last_bit_nxt;
   logic [7:0]        rep_cnt, rep_cnt_nxt;
   logic              hf_nxt, to_nxt;

   logic done_s, done_d, done_rise, bit_s;
   logic [7:0] rep_sum;
   logic       rep_trip;

   hyster_sync2 u_sync_done (.clk(clk), .rst(rst), .d(core_done), .q(done_s));
   hyster_sync2 u_sync_bit  (.clk(clk), .rst(rst), .d(core_bit),  .q(bit_s));

   assign done_rise = done_s & ~done_d;

   // rep_cnt==0 means no history (after reset or clr), so the next bit starts a run
   assign rep_sum  = (rep_cnt != 8'd0 && bit_s == last_bit)
                   ? ((rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1)
                   : 8'd1;
   assign rep_trip = (rep_sum >= 8'(REP_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rst_cnt     <= '0;
         tmo_cnt     <= '0;
         bit_cnt     <= '0;
         rnd_word    <= '0;
         last_bit    <= 1'b0;
         rep_cnt     <= '0;
         health_fail <= 1'b0;
         timeout_err <= 1'b0;
         done_d      <= 1'b0;
         core_rst_b  <= 1'b0;
         rnd_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         rst_cnt     <= rst_cnt_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         bit_cnt     <= bit_cnt_nxt;
         rnd_word    <= word_nxt;
         last_bit    <= last_bit_nxt;
         rep_cnt     <= rep_cnt_nxt;
         health_fail <= hf_nxt;
         timeout_err <= to_nxt;
         done_d      <= done_s;
         // outputs are registered from the next state so they align with it
         core_rst_b  <= (state_nxt == WAIT_DONE);
         rnd_valid   <= (state_nxt == OUTPUT);
         busy        <= (state_nxt inside {RESET_CORE, WAIT_DONE, OUTPUT});
      end
   end

   always_comb begin
      state_nxt    = state;
      rst_cnt_nxt  = rst_cnt;
      tmo_cnt_nxt  = tmo_cnt;
      bit_cnt_nxt  = bit_cnt;
      word_nxt     = rnd_word;
      last_bit_nxt = last_bit;
      rep_cnt_nxt  = rep_cnt;
      hf_nxt       = health_fail;
      to_nxt       = timeout_err;

      case (state)
         IDLE: begin
            if (en) begin
               state_nxt   = RESET_CORE;
               rst_cnt_nxt = 8'(RST_CYC - 1);
            end
         end
         RESET_CORE: begin
            if (!en) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end else if (rst_cnt == 8'd0) begin
               state_nxt   = WAIT_DONE;
               tmo_cnt_nxt = '0;
            end else begin
               rst_cnt_nxt = rst_cnt - 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!en) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end else if (done_rise) begin
               // a bit arriving on the timeout cycle still wins
               word_nxt     = {rnd_word[WORD_W-2:0], bit_s};
               bit_cnt_nxt  = bit_cnt + 1'b1;
               last_bit_nxt = bit_s;
               rep_cnt_nxt  = rep_sum;
               if (rep_trip) begin
                  hf_nxt    = 1'b1;
                  state_nxt = FAIL;
               end else if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                  state_nxt = OUTPUT;
               end else begin
                  state_nxt   = RESET_CORE;
                  rst_cnt_nxt = 8'(RST_CYC - 1);
               end
            end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
               to_nxt    = 1'b1;
               state_nxt = FAIL;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
         end
         OUTPUT: begin
            if (rnd_ready) begin
               bit_cnt_nxt = '0;
               if (en) begin
                  state_nxt   = RESET_CORE;
                  rst_cnt_nxt = 8'(RST_CYC - 1);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         FAIL: begin
            if (clr) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (clr) begin
         hf_nxt       = 1'b0;
         to_nxt       = 1'b0;
         rep_cnt_nxt  = '0;
         last_bit_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_hyster_seq.sv
module tb_hyster_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clr;
   logic       core_rst_b;
   logic       core_done = 1'b0;
   logic       core_bit  = 1'b0;
   logic [7:0] rnd_word;
   logic       rnd_valid;
   logic       rnd_ready;
   logic       busy;
   logic       health_fail;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   // bit stream served by the core model, one bit per core reset release
   localparam logic [47:0] SEQ = {8'hB2, 8'h69, 8'hD6, 3'b101, 8'h65, 5'b01111, 8'h9A};
   logic model_bits [0:47];
   int   bidx = 0;
   logic hang = 1'b0;

   hyster_seq #(
      .WORD_W(8), .RST_CYC(4), .TIMEOUT(16), .REP_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .core_rst_b(core_rst_b), .core_done(core_done), .core_bit(core_bit),
      .rnd_word(rnd_word), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .busy(busy), .health_fail(health_fail), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // core model: done 20 ns after rst_b release, cleared while rst_b is low
   always @(core_rst_b) begin
      if (core_rst_b !== 1'b1) begin
         core_done = 1'b0;
      end else if (!hang) begin
         #20;
         if (core_rst_b === 1'b1 && bidx < 48) begin
            core_bit  = model_bits[bidx];
            bidx      = bidx + 1;
            core_done = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig_sel(input int sel);
      case (sel)
         0:       return rnd_valid;
         1:       return core_rst_b;
         2:       return health_fail;
         3:       return timeout_err;
         default: return ~core_rst_b;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int max);
      int n = 0;
      while (sig_sel(sel) !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(sig_sel(sel)), 64'd1);
   endtask

   initial begin
      logic [47:0] seq_v;
      logic [7:0]  held;
      int          bad;
      int          n;
      logic        saw_valid;

      seq_v = SEQ;
      for (int i = 0; i < 48; i++) model_bits[i] = seq_v[47-i];

      rst = 1'b1; en = 1'b0; clr = 1'b0; rnd_ready = 1'b0;
      @(negedge clk);
      check("rst_core_rst_b", 64'(core_rst_b), 64'd0);
      check("rst_rnd_word", 64'(rnd_word), 64'd0);
      check("rst_rnd_valid", 64'(rnd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_health_fail", 64'(health_fail), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single word with ready already high
      rnd_ready = 1'b1; en = 1'b1;
      wait_for("w1_valid_timeout", 0, 600);
      check("w1_word", 64'(rnd_word), 64'hB2);
      check("w1_captures", 64'(bidx), 64'd8);
      @(negedge clk);
      check("w1_valid_one_cycle", 64'(rnd_valid), 64'd0);
      check("w1_busy_after", 64'(busy), 64'd1);
      check("w1_core_rst_b_after", 64'(core_rst_b), 64'd0);
      rnd_ready = 1'b0;

      // backpressure: word and core reset held while not accepted
      wait_for("w2_valid_timeout", 0, 600);
      check("w2_word", 64'(rnd_word), 64'h69);
      held = rnd_word;
      bad  = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rnd_word !== held || rnd_valid !== 1'b1 || core_rst_b !== 1'b0) bad++;
      end
      check("w2_stable_cycles_bad", 64'(bad), 64'd0);
      rnd_ready = 1'b1;
      @(negedge clk);
      check("w2_valid_after_ready", 64'(rnd_valid), 64'd0);
      wait_for("w3_valid_timeout", 0, 600);
      check("w3_word", 64'(rnd_word), 64'hD6);
      en = 1'b0;
      @(negedge clk);
      check("w3_idle_after_handshake", 64'(busy), 64'd0);
      check("w3_valid_dropped", 64'(rnd_valid), 64'd0);

      // abort after 3 bits, then a clean word
      en = 1'b1;
      n = 0;
      while (bidx < 27 && n < 600) begin @(negedge clk); n++; end
      check("ab_three_bits", 64'(bidx), 64'd27);
      wait_for("ab_reset_core_timeout", 4, 50);
      en = 1'b0;
      @(negedge clk);
      check("ab_idle", 64'(busy), 64'd0);
      check("ab_core_rst_b", 64'(core_rst_b), 64'd0);
      en = 1'b1;
      wait_for("ab_valid_timeout", 0, 600);
      check("ab_word", 64'(rnd_word), 64'h65);
      check("ab_captures", 64'(bidx), 64'd35);
      en = 1'b0;
      @(negedge clk);
      check("ab_idle_after", 64'(busy), 64'd0);

      // health failure on fourth repeated 1
      en = 1'b1;
      saw_valid = 1'b0;
      n = 0;
      while (health_fail !== 1'b1 && n < 600) begin
         @(negedge clk);
         if (rnd_valid === 1'b1) saw_valid = 1'b1;
         n++;
      end
      check("hf_flag", 64'(health_fail), 64'd1);
      check("hf_captures", 64'(bidx), 64'd40);
      check("hf_no_valid", 64'(saw_valid), 64'd0);
      check("hf_busy", 64'(busy), 64'd0);
      check("hf_core_rst_b", 64'(core_rst_b), 64'd0);
      check("hf_no_timeout", 64'(timeout_err), 64'd0);
      repeat (3) @(negedge clk);
      check("hf_stays_fail", 64'(busy), 64'd0);
      en = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("hf_cleared", 64'(health_fail), 64'd0);
      check("hf_idle", 64'(busy), 64'd0);

      // timeout: core never answers
      hang = 1'b1; en = 1'b1;
      wait_for("to_release_timeout", 1, 100);
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("to_cycles", 64'(n), 64'd16);
      check("to_flag", 64'(timeout_err), 64'd1);
      check("to_core_rst_b", 64'(core_rst_b), 64'd0);
      check("to_busy", 64'(busy), 64'd0);
      en = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("to_cleared", 64'(timeout_err), 64'd0);
      hang = 1'b0;

      // async reset mid WAIT_DONE
      en = 1'b1;
      wait_for("ar1_release_timeout", 1, 100);
      #2 rst = 1'b1;
      #1 check("ar1_outputs", {55'd0, core_rst_b, rnd_valid, busy, health_fail, timeout_err, rnd_word[3:0]}, 64'd0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ar1_idle", 64'({busy, core_rst_b}), 64'd0);
      check("ar1_no_capture", 64'(bidx), 64'd40);

      // async reset mid OUTPUT
      en = 1'b1; rnd_ready = 1'b0;
      wait_for("ar2_valid_timeout", 0, 600);
      check("ar2_word", 64'(rnd_word), 64'h9A);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("ar2_outputs", {50'd0, core_rst_b, rnd_valid, busy, health_fail, timeout_err, 1'b0, rnd_word}, 64'd0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("ar2_idle", 64'({busy, rnd_valid, core_rst_b}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hyster_seq.md
# hyster_seq

Sequencer for the hysteresis ring-oscillator RNG core. Runs in the system clock domain. Repeatedly restarts the core through its active-low reset, synchronizes and captures each `done`/`rnd_bit` result, and packs the bits into words. Applies a repetition-count health test and a per-bit timeout, then presents words to a single consumer over a valid/ready handshake.

## Interface

Parameters:
- `WORD_W`, 32: bits per output word, range 2..64.
- `RST_CYC`, 8: `clk` cycles `core_rst_b` is held low per bit, range 4..255.
- `TIMEOUT`, 4096: `clk` cycles allowed in WAIT_DONE before declaring a timeout, range 16..65535.
- `REP_LIMIT`, 16: consecutive identical bits that trip the health test, range 2..255.

Ports:
- `clk`  in  1  system clock. Single clock domain; the only clock in this block.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  run request, level-sensitive.
- `clr`  in  1  one-cycle pulse; clears the sticky errors and returns the FSM from FAIL to IDLE.
- `core_rst_b`  out  1  drives the core's `rst_b`.
- `core_done`  in  1  core `done`; asynchronous to `clk`.
- `core_bit`  in  1  core `rnd_bit`; asynchronous to `clk`, stable while `core_done` is high.
- `rnd_word`  out  WORD_W  assembled word.
- `rnd_valid`  out  1  `rnd_word` is valid.
- `rnd_ready`  in  1  consumer accepts the word.
- `busy`  out  1  FSM is not in IDLE and not in FAIL.
- `health_fail`  out  1  sticky repetition-test failure.
- `timeout_err`  out  1  sticky timeout failure.

## Operation

- **Synchronizers.** `core_done` and `core_bit` each pass through a 2-flop synchronizer. A third flop on synced done provides rising-edge detection (`done_rise`).
- **States.** IDLE, RESET_CORE, WAIT_DONE, OUTPUT, FAIL.
- **IDLE**
  - `core_rst_b`=0.
  - `en`=1 → RESET_CORE.
- **RESET_CORE**
  - `core_rst_b`=0.
  - A down-counter is loaded with RST_CYC-1 on entry. At 0 → WAIT_DONE.
- **WAIT_DONE**
  - `core_rst_b`=1.
  - A timeout counter starts at 0 on entry.
  - On `done_rise`:
    - Shift the synced bit into the word: `word <= {word[WORD_W-2:0], bit}` (first bit ends up as MSB).
    - Increment `bit_cnt` and update the repetition test.
    - Next state: `bit_cnt`==WORD_W-1 before the increment → OUTPUT. Otherwise → RESET_CORE.
  - Timeout counter reaches TIMEOUT-1 without `done_rise` → `timeout_err`=1, FAIL.
- **Repetition test**
  - Tracks `last_bit` and `rep_cnt`.
  - Same bit → `rep_cnt`+1, saturating. Different bit → `rep_cnt`=1.
  - `rep_cnt` reaching REP_LIMIT → `health_fail`=1, FAIL.
  - Health failure takes priority over word completion on the same bit.
  - The repetition state persists across words. It is cleared only by `rst` or `clr`.
- **OUTPUT**
  - `rnd_valid`=1. `rnd_word` is held stable; `core_rst_b`=0.
  - On `rnd_valid & rnd_ready`: `bit_cnt`=0. Next state is RESET_CORE if `en`, else IDLE.
- **FAIL**
  - `core_rst_b`=0, `rnd_valid`=0.
  - Stays until `clr` → IDLE, which clears both sticky flags, `rep_cnt` and `bit_cnt`.
- **`en` deasserted**
  - In RESET_CORE or WAIT_DONE → IDLE next cycle. The partial word is discarded and `bit_cnt`=0.
  - In OUTPUT it has no effect until the handshake completes.
- **Simultaneous events**
  - `clr` in a state other than FAIL clears only the sticky flags and the repetition state; the FSM is unaffected.
  - `done_rise` in the same cycle as timeout expiry → the bit is accepted and no timeout is raised.

## Timing

- **Reset values:** `core_rst_b`=0, `rnd_word`=0, `rnd_valid`=0, `busy`=0, `health_fail`=0, `timeout_err`=0. State is IDLE.
- **Outputs are registered.**
  - `core_rst_b` rises on the first WAIT_DONE cycle.
  - `rnd_valid` rises on the cycle after the final `done_rise`.
- **Per-bit sequence:** 1 entry cycle into RESET_CORE + RST_CYC low cycles + core settling time + 3 cycles synchronizer/edge latency + 1 capture cycle.
- **Stale `done` is impossible.** RST_CYC≥4 guarantees synced done is low before WAIT_DONE is entered.
- **Handshake**
  - `rnd_word` must not change while `rnd_valid`=1.
  - `rnd_ready` may be high before `rnd_valid`. The transfer happens on the first cycle where both are high.
  - The earliest next `rnd_valid` is at least WORD_W·(RST_CYC+5) cycles later.
- **Mid-operation reset:** asynchronous `rst` forces all outputs to their reset values immediately. `core_rst_b` goes low combinationally with the flop reset.

## Structure

- **Package `hyster_pkg`:**
  - `hseq_state_t` enum: IDLE, RESET_CORE, WAIT_DONE, OUTPUT, FAIL.
  - Default parameter constants.
- **Sub-module `hyster_sync2`:** 2-flop synchronizer with async active-high reset, instantiated twice.
- **Top-level integration:** `hyster_seq` instantiates neither the core nor the oscillators; the top level wires `core_rst_b`, `core_done` and `core_bit` to the core.

## Test plan

1. **Single word.** WORD_W=8, RST_CYC=4. Behavioral core model returns bits 1,0,1,1,0,0,1,0, with `done` 20 ns after `rst_b` release. `rnd_ready`=1 → exactly one `rnd_valid` pulse with `rnd_word`=8'hB2, then RESET_CORE.
2. **Backpressure.** `rnd_ready` held 0 for 50 cycles after `rnd_valid` → `rnd_word` stable, `core_rst_b`=0 throughout. Handshake on cycle 51, next word collected.
3. **Health failure.** REP_LIMIT=4, model outputs 0,1,1,1,1 → `health_fail`=1 on the 5th capture, FAIL, no `rnd_valid`. `clr` → IDLE, flags 0.
4. **Timeout.** TIMEOUT=16, model never asserts `done` → `timeout_err`=1 exactly 16 cycles into WAIT_DONE, `core_rst_b`=0 the next cycle.
5. **Abort.** `en` dropped after 3 of 8 bits → IDLE next cycle. On re-enable, the first word contains only newly captured bits.
6. **Async reset.** `rst` asserted mid-WAIT_DONE and mid-OUTPUT → all outputs at reset values within the same cycle, IDLE after release.
